matrix_mem_loader: RTL

Host-side data-memory loader and result drainer for the matrix-multiplication processor. It accepts operand bytes from a host byte stream and writes them into data memory. It then releases the processor by asserting `proc_run` and waits for `end_process`. Finally it reads the result region back out of data memory and streams it to the host. It owns the data-memory port whenever `proc_run` is low.

---
 rtl/matrix_mem_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/matrix_mem_loader.sv
// Host loader/drainer for the matrix processor data memory.
// Loads operands, runs the processor, then streams results back.
module matrix_mem_loader #(
  parameter int ADDR_W    = 16,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 18,
  parameter int RES_BASE  = 18,
  parameter int RES_LEN   = 9
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [7:0]        dm_wdata,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [7:0]        dm_rdata,
  output logic              proc_run,
  input  logic              end_process,
  output logic              done
);

  localparam int MAX_LEN = (LOAD_LEN > RES_LEN) ? LOAD_LEN : RES_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_RD,
    S_CAP,
    S_OUT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             done_nx;
  // Holds off in_ready until the first edge after reset release
  logic             armed;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= S_LOAD;
      cnt      <= '0;
      armed    <= 1'b0;
      done     <= 1'b0;
      out_data <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      armed <= 1'b1;
      done  <= done_nx;
      if (state == S_CAP) begin
        out_data <= dm_rdata;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    done_nx   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    proc_run  = 1'b0;
    dm_addr   = '0;
    dm_wdata  = 8'h00;
    dm_we     = 1'b0;
    dm_re     = 1'b0;
    unique case (state)
      S_LOAD: begin
        in_ready = armed;
        if (in_valid && armed) begin
          dm_we    = 1'b1;
          dm_addr  = ADDR_W'(LOAD_BASE) + ADDR_W'(cnt);
          dm_wdata = in_data;
          if (cnt == CNT_W'(LOAD_LEN - 1)) begin
            cnt_nx   = '0;
            state_nx = S_RUN;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_RUN: begin
        proc_run = 1'b1;
        if (end_process) begin
          state_nx = S_RD;
        end
      end
      S_RD: begin
        dm_re    = 1'b1;
        dm_addr  = ADDR_W'(RES_BASE) + ADDR_W'(cnt);
        state_nx = S_CAP;
      end
      S_CAP: begin
        state_nx = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt == CNT_W'(RES_LEN - 1)) begin
            cnt_nx   = '0;
            done_nx  = 1'b1;
            state_nx = S_LOAD;
          end else begin
            cnt_nx   = cnt + 1'b1;
            state_nx = S_RD;
          end
        end
      end
      default: begin
        state_nx = S_LOAD;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule
